err_weight_batcher: RTL

Transmit-side feeder for the best-weight comparator (`cmp`). Accepts one complete candidate (error + full weight vector, FloPoCo 34-bit format) per handshake. Replays it to the comparator as `Num_Unknowns/Num_Unknown_Per_Batch` consecutive batches on `current_err`/`current_weights`. Sits between the NN weight-update stage and `cmp`.

---
 rtl/nn_accel_pkg.sv | 32 +++
 rtl/err_weight_batcher.sv | 111 +++++++++++
 2 files changed

// File: rtl/nn_accel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_accel_pkg
//  Description : Shared FloPoCo exception codes, batcher state encoding and
//                width/batch-count helpers for the NN accelerator datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package nn_accel_pkg;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } batcher_state_t;

    function automatic int calc_w(input int element_width, input int extra);
        return element_width + extra;
    endfunction

    // Returns 0 when the batch size does not evenly divide the vector length.
    function automatic int calc_nb(input int num_unknowns, input int per_batch);
        if (per_batch <= 0 || (num_unknowns % per_batch) != 0)
            return 0;
        return num_unknowns / per_batch;
    endfunction

endpackage
`default_nettype wire

// File: rtl/err_weight_batcher.sv
`default_nettype none
// ============================================================================
//  Module      : err_weight_batcher
//  Description : Captures one error + weight-vector candidate per handshake
//                and replays it to the comparator as consecutive batches.
//  Revision    : 1.0 - initial release
// ============================================================================
module err_weight_batcher
    import nn_accel_pkg::*;
#(
    parameter  int ELEMENT_WIDTH         = 32,
    parameter  int Extra                 = 2,
    parameter  int Num_Unknowns          = 4,
    parameter  int Num_Unknown_Per_Batch = 2,
    localparam int c_W                   = calc_w(ELEMENT_WIDTH, Extra)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [c_W-1:0]                       in_err,
    input  logic [c_W*Num_Unknowns-1:0]          in_weights,
    input  logic                                 hold,
    output logic [c_W-1:0]                       current_err,
    output logic [c_W*Num_Unknown_Per_Batch-1:0] current_weights,
    output logic                                 batch_valid,
    output logic                                 first_batch,
    output logic                                 last_batch,
    output logic [7:0]                           drop_cnt
);

    localparam int c_NB = calc_nb(Num_Unknowns, Num_Unknown_Per_Batch);
    localparam int c_BW = c_W * Num_Unknown_Per_Batch;
    localparam int c_VW = c_W * Num_Unknowns;
    localparam int c_IW = (c_NB > 1) ? $clog2(c_NB) : 1;
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'((c_NB > 0) ? c_NB - 1 : 0);

    generate
        if (c_NB == 0) begin : g_bad_params
            $error("Num_Unknown_Per_Batch must divide Num_Unknowns");
        end
    endgenerate

    batcher_state_t    r_state;
    logic [c_IW-1:0]   r_idx;
    logic [c_VW-1:0]   r_weights;

    logic              w_nan;
    logic              w_accept;
    logic              w_start;
    logic [c_IW-1:0]   w_idx_next;
    logic [c_BW-1:0]   w_slices [c_NB];

    // Batch k is the k-th slice counted from the MSB end of the held vector.
    generate
        for (genvar k = 0; k < c_NB; k++) begin : g_slice
            assign w_slices[k] = r_weights[c_VW-1-k*c_BW -: c_BW];
        end
    endgenerate

    assign w_nan      = (in_err[c_W-1 -: 2] == EXC_NAN);
    assign in_ready   = (r_state == IDLE) ||
                        ((r_state == SEND) && (r_idx == c_LAST_IDX) && !hold);
    assign w_accept   = in_valid && in_ready;
    assign w_start    = w_accept && !w_nan;
    assign w_idx_next = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= IDLE;
            r_idx           <= '0;
            r_weights       <= '0;
            current_err     <= '0;
            current_weights <= '0;
            batch_valid     <= 1'b0;
            first_batch     <= 1'b0;
            last_batch      <= 1'b0;
            drop_cnt        <= '0;
        end else begin
            if (w_accept && w_nan && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;

            // A NaN accept is consumed but falls through as if nothing arrived.
            if (w_start) begin
                r_state         <= SEND;
                r_idx           <= '0;
                r_weights       <= in_weights;
                current_err     <= in_err;
                current_weights <= in_weights[c_VW-1 -: c_BW];
                batch_valid     <= 1'b1;
                first_batch     <= 1'b1;
                last_batch      <= (c_NB == 1);
            end else if (r_state == SEND && !hold) begin
                if (r_idx != c_LAST_IDX) begin
                    r_idx           <= w_idx_next;
                    current_weights <= w_slices[w_idx_next];
                    first_batch     <= 1'b0;
                    last_batch      <= (w_idx_next == c_LAST_IDX);
                end else begin
                    r_state     <= IDLE;
                    r_idx       <= '0;
                    batch_valid <= 1'b0;
                    first_batch <= 1'b0;
                    last_batch  <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
